// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   - Active-low segment patterns {g,f,e,d,c,b,a} for 0..9, dash and blank.
//   - One-hot digit position codes, also used by the digit-sequencing FSM.
//   - Scan state encoding and a helper that classifies a position code.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] POS_NONE  = 4'h0;
    localparam logic [3:0] POS_3     = 4'h8;
    localparam logic [3:0] POS_2     = 4'h4;
    localparam logic [3:0] POS_1     = 4'h2;
    localparam logic [3:0] POS_0     = 4'h1;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    // A position code is legal when it is "no write" or exactly one position.
    function automatic logic sel_is_illegal(input logic [3:0] sel);
        logic bad;
        case (sel)
            POS_NONE, POS_3, POS_2, POS_1, POS_0: bad = 1'b0;
            default:                              bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low 7-segment decoder.
// Ports:
//   digit  in  4  digit value; 0..9 decode to numerals, A..F show a dash
//   blank  in  1  force all segments off
//   seg    out 7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pattern lookup; non-BCD codes fall through to the dash pattern.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: captures digits from the sequencing FSM into a shadow
// bank, commits complete frames atomically, and time-multiplexes them onto a
// 4-digit common-anode display with a blanking gap at the start of each slot.
// Ports:
//   clk        in  1  system clock
//   rst        in  1  synchronous active-high reset
//   digit_in   in  4  BCD digit from the FSM
//   digit_sel  in  4  one-hot position (8 = leftmost .. 1 = rightmost), 0 = idle
//   an_n       out 4  anode enables, active-low, bit3 = leftmost
//   seg_n      out 7  segments, active-low {g,f,e,d,c,b,a}
//   dp_n       out 1  decimal point, active-low, always off
//   sel_err    out 1  one-cycle pulse after an illegal digit_sel
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit LZB_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic [3:0] digit_sel,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       sel_err
);

    localparam int             CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [3:0][3:0]  shadow_r;
    logic [3:0][3:0]  disp_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       slot_r;
    scan_state_t      state_r;
    scan_state_t      state_s;
    logic             wrap_s;
    logic [3:0]       cur_digit_s;
    logic             blank_s;
    logic [6:0]       dec_seg_s;
    logic [3:0]       an_n_r;
    logic [6:0]       seg_n_r;
    logic             sel_err_r;

    assign wrap_s  = (cnt_r == CNT_LAST);
    assign an_n    = an_n_r;
    assign seg_n   = seg_n_r;
    assign sel_err = sel_err_r;
    assign dp_n    = 1'b1;

    // Shadow capture; a position-0 write publishes the whole frame at once,
    // taking digit 0 straight from the input since shadow[0] updates on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r  <= '0;
            disp_r    <= '0;
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= sel_is_illegal(digit_sel);
            case (digit_sel)
                POS_3: shadow_r[3] <= digit_in;
                POS_2: shadow_r[2] <= digit_in;
                POS_1: shadow_r[1] <= digit_in;
                POS_0: begin
                    shadow_r[0] <= digit_in;
                    disp_r      <= {shadow_r[3], shadow_r[2], shadow_r[1], digit_in};
                end
                default: ;
            endcase
        end
    end

    // Phase counter and slot index; slots run leftmost to rightmost.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            slot_r <= 2'd3;
        end else if (wrap_s) begin
            cnt_r  <= '0;
            slot_r <= slot_r - 2'd1;
        end else begin
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            slot_r <= slot_r;
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_BLANK;
        end else begin
            state_r <= state_s;
        end
    end

    // Next scan state: ON once the counter reaches BLANK_CYCLES, BLANK again at the wrap.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = S_ON;
                end else begin
                    state_s = S_BLANK;
                end
            end
            S_ON: begin
                if (wrap_s) begin
                    state_s = S_BLANK;
                end else begin
                    state_s = S_ON;
                end
            end
            default: state_s = S_BLANK;
        endcase
    end

    // Current slot digit and leading-zero blanking, judged on the committed frame.
    always_comb begin
        cur_digit_s = disp_r[slot_r];
        blank_s     = 1'b0;
        if (LZB_EN) begin
            case (slot_r)
                2'd3:    blank_s = (disp_r[3] == 4'd0);
                2'd2:    blank_s = (disp_r[3] == 4'd0) && (disp_r[2] == 4'd0);
                2'd1:    blank_s = (disp_r[3] == 4'd0) && (disp_r[2] == 4'd0)
                                   && (disp_r[1] == 4'd0);
                default: blank_s = 1'b0;
            endcase
        end else begin
            blank_s = 1'b0;
        end
    end

    bcd_to_seg7 u_dec (
        .digit (cur_digit_s),
        .blank (blank_s),
        .seg   (dec_seg_s)
    );

    // Registered display drive, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_n_r  <= 4'hF;
            seg_n_r <= SEG_BLANK;
        end else if (state_r == S_ON) begin
            an_n_r  <= ~(4'b0001 << slot_r);
            seg_n_r <= dec_seg_s;
        end else begin
            an_n_r  <= 4'hF;
            seg_n_r <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV = 8, BLANK_CYCLES = 2.
// Two instances share the inputs: one with leading-zero blanking, one without.
// Cycle numbering: cyc = number of clock edges since rst was last sampled high.
// With these parameters the first ON output of slot event k appears at
// cyc = 3 + 8k and shows slot 3 - (k mod 4); each ON run lasts 6 cycles.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit_in  = 4'h0;
    logic [3:0] digit_sel = 4'h0;

    logic [3:0] an_n_a, an_n_b;
    logic [6:0] seg_n_a, seg_n_b;
    logic       dp_n_a, dp_n_b;
    logic       sel_err_a, sel_err_b;

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .LZB_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_sel(digit_sel),
        .an_n(an_n_a), .seg_n(seg_n_a), .dp_n(dp_n_a), .sel_err(sel_err_a)
    );

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .LZB_EN(1'b0)) dut_nolzb (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_sel(digit_sel),
        .an_n(an_n_b), .seg_n(seg_n_b), .dp_n(dp_n_b), .sel_err(sel_err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg_a;
        logic [6:0] seg_b;
    } ev_t;

    ev_t  exp_q[$];
    int   sel_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic rst_q       = 1'b0;

    // Bench cycle reference.
    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: reset state, slot events against the scoreboard, ON-run length, sel_err pulses.
    bit  prev_on = 1'b0;
    int  evk     = 0;
    int  run     = 0;
    ev_t e;
    always @(negedge clk) begin
        if (rst_q) begin
            vectors++;
            if (an_n_a !== 4'hF || seg_n_a !== 7'h7F || sel_err_a !== 1'b0 || dp_n_a !== 1'b1 ||
                an_n_b !== 4'hF || seg_n_b !== 7'h7F || sel_err_b !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: an_n=%h seg_n=%h sel_err=%b dp_n=%b (nolzb an_n=%h seg_n=%h), required an_n=f seg_n=7f sel_err=0 dp_n=1",
                         an_n_a, seg_n_a, sel_err_a, dp_n_a, an_n_b, seg_n_b);
            end
            prev_on = 1'b0;
            evk     = 0;
            run     = 0;
        end else begin
            if (sel_err_a === 1'b1) begin
                vectors++;
                if (sel_q.size() > 0 && sel_q[0] == cyc && sel_err_b === 1'b1) begin
                    void'(sel_q.pop_front());
                end else begin
                    miscompares++;
                    $display("FAIL sel_err_pulse: high at cyc=%0d (nolzb=%b), required next pulse at cyc=%0d",
                             cyc, sel_err_b, (sel_q.size() > 0) ? sel_q[0] : -1);
                end
            end
            if (an_n_a !== 4'hF) begin
                if (!prev_on) begin
                    vectors++;
                    if (cyc != 3 + 8 * evk) begin
                        miscompares++;
                        $display("FAIL slot_timing k=%0d: first ON at cyc=%0d, required cyc=%0d",
                                 evk, cyc, 3 + 8 * evk);
                    end
                    while (exp_q.size() > 0 && exp_q[0].k < evk) begin
                        e = exp_q.pop_front();
                        vectors++;
                        miscompares++;
                        $display("FAIL slot_missed k=%0d: not presented, now at event %0d", e.k, evk);
                    end
                    if (exp_q.size() > 0 && exp_q[0].k == evk) begin
                        e = exp_q.pop_front();
                        vectors++;
                        if (an_n_a !== e.an || seg_n_a !== e.seg_a || an_n_b !== e.an ||
                            seg_n_b !== e.seg_b || dp_n_a !== 1'b1 || dp_n_b !== 1'b1) begin
                            miscompares++;
                            $display("FAIL slot_event k=%0d: an_n=%h seg_n=%h nolzb an_n=%h seg_n=%h dp_n=%b%b, required an_n=%h seg_n=%h nolzb seg_n=%h dp_n=11",
                                     evk, an_n_a, seg_n_a, an_n_b, seg_n_b, dp_n_a, dp_n_b,
                                     e.an, e.seg_a, e.seg_b);
                        end
                    end
                    evk++;
                end
                run++;
                prev_on = 1'b1;
            end else begin
                if (prev_on) begin
                    vectors++;
                    if (run != 6) begin
                        miscompares++;
                        $display("FAIL on_run_length: %0d ON cycles, required 6", run);
                    end
                end
                run     = 0;
                prev_on = 1'b0;
            end
        end
    end

    task automatic push_ev(input int k, input logic [3:0] an, input logic [6:0] sa, input logic [6:0] sb);
        ev_t x;
        x.k = k; x.an = an; x.seg_a = sa; x.seg_b = sb;
        exp_q.push_back(x);
    endtask

    // One full rotation starting at slot 3; a* with blanking, b* without.
    task automatic push_rot(input int k0,
                            input logic [6:0] a3, input logic [6:0] a2, input logic [6:0] a1, input logic [6:0] a0,
                            input logic [6:0] b3, input logic [6:0] b2, input logic [6:0] b1, input logic [6:0] b0);
        push_ev(k0,     4'h7, a3, b3);
        push_ev(k0 + 1, 4'hB, a2, b2);
        push_ev(k0 + 2, 4'hD, a1, b1);
        push_ev(k0 + 3, 4'hE, a0, b0);
    endtask

    // Present a write so that edge number m samples it.
    task automatic write_at(input int m, input logic [3:0] sel, input logic [3:0] d);
        while (cyc < m - 1) @(negedge clk);
        vectors++;
        if (cyc != m - 1) begin
            miscompares++;
            $display("FAIL write_schedule: at cyc=%0d, required cyc=%0d", cyc, m - 1);
        end
        digit_sel = sel;
        digit_in  = d;
        @(negedge clk);
        digit_sel = 4'h0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset frame: all zero, only slot 0 lit under blanking.
        push_rot(0, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

        // Frame commit 1,0,0,0.
        push_rot(4, 7'h79, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40);
        write_at(28, 4'h8, 4'd1);
        write_at(29, 4'h4, 4'd0);
        write_at(30, 4'h2, 4'd0);
        write_at(31, 4'h1, 4'd0);

        // Partial writes must not reach the display for two rotations.
        push_rot(8,  7'h79, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40);
        push_rot(12, 7'h79, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40, 7'h40);
        write_at(40, 4'h8, 4'd9);
        write_at(41, 4'h4, 4'd5);
        push_rot(16, 7'h10, 7'h12, 7'h30, 7'h78, 7'h10, 7'h12, 7'h30, 7'h78);
        write_at(124, 4'h2, 4'd3);
        write_at(125, 4'h1, 4'd7);

        // Leading-zero blanking on 0,0,4,0.
        push_rot(20, 7'h7F, 7'h7F, 7'h19, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40);
        write_at(156, 4'h8, 4'd0);
        write_at(157, 4'h4, 4'd0);
        write_at(158, 4'h2, 4'd4);
        write_at(159, 4'h1, 4'd0);

        // Illegal selects leave the shadow alone; recommit shows the same frame.
        push_rot(24, 7'h7F, 7'h7F, 7'h19, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40);
        sel_q.push_back(188);
        write_at(188, 4'b0110, 4'd8);
        write_at(189, 4'h1, 4'd0);
        sel_q.push_back(190);
        write_at(190, 4'b1111, 4'd8);

        // Non-BCD digit shows a dash.
        push_rot(28, 7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h40);
        write_at(220, 4'h2, 4'hC);
        write_at(221, 4'h1, 4'd0);

        // Commit 1,2,3,4, then reset during slot 1 ON.
        push_rot(32, 7'h79, 7'h24, 7'h30, 7'h19, 7'h79, 7'h24, 7'h30, 7'h19);
        write_at(252, 4'h8, 4'd1);
        write_at(253, 4'h4, 4'd2);
        write_at(254, 4'h2, 4'd3);
        write_at(255, 4'h1, 4'd4);
        push_ev(36, 4'h7, 7'h79, 7'h79);
        push_ev(37, 4'hB, 7'h24, 7'h24);
        push_ev(38, 4'hD, 7'h30, 7'h30);
        wait_cyc(308);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // After reset the display is back to the blanked all-zero frame.
        push_rot(0, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        wait_cyc(40);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d slot events left unpresented, required 0", exp_q.size());
        end
        vectors++;
        if (sel_q.size() != 0) begin
            miscompares++;
            $display("FAIL sel_err_drain: %0d sel_err pulses missing, required 0", sel_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
